edge_frame_sequencer: RTL and testbench
=======================================

EDGE_FRAME_SEQUENCER -- requirements
Module: edge_frame_sequencer

Interface
REQ-001 Parameter ROW, default 125, image width in pixels (column addresses per row).
REQ-002 Parameter ROWS, default 250, image height in pixels.
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 LOCKED  input  1  clock-manager lock; when low, all state, counters and outputs hold.
REQ-007 start  input  1  one-cycle request to begin a frame pass.
REQ-008 rom_addr  output  15  pixel ROM read address.
REQ-009 rom_en  output  1  ROM read enable.
REQ-010 rom_data  input  PIX_W  ROM read data, valid exactly one cycle after rom_en.
REQ-011 col_top / col_mid / col_bot  output  PIX_W each  assembled 3-pixel column: rows r, r+1, r+2.
REQ-012 col_addr  output  15  linear index of col_top pixel for the presented column.
REQ-013 col_valid  output  1  column presented; held until col_ready.
REQ-014 col_ready  input  1  downstream (Sobel core) accepts column when col_valid & col_ready.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 State machine SHALL have states IDLE, RD0, RD1, RD2, CAP, HOLD, DONE.
REQ-018 IDLE -> RD0 when start=1 and LOCKED=1; start in any other state SHALL be ignored.
REQ-019 RD0: rom_en=1, rom_addr=cnt; next RD1.
REQ-020 RD1: rom_en=1, rom_addr=cnt+ROW; col_top <= rom_data; next RD2.
REQ-021 RD2: rom_en=1, rom_addr=cnt+2*ROW; col_mid <= rom_data; next CAP.
REQ-022 CAP: rom_en=0; col_bot <= rom_data; next HOLD.
REQ-023 HOLD: col_valid=1, col_addr=cnt; col_top/mid/bot stable; stay until col_ready=1.
REQ-024 On HOLD handshake: if cnt == LAST (ROW*(ROWS-2)-1 = 30999 by default) go DONE with cnt <= 0, else cnt <= cnt+1 and go RD0.
REQ-025 DONE: done=1 for exactly one cycle; next IDLE.
REQ-026 Minimum throughput one column per 5 cycles; col_ready held high SHALL give zero extra stall cycles.
REQ-027 Address arithmetic 15-bit unsigned; maximum address ROW*ROWS-1 = 31249, no wrap permitted; cnt SHALL never exceed LAST.
REQ-028 LOCKED=0 in any state: no state transition, no cnt change, rom_en forced 0, col_valid and done held at their current values; the interrupted ROM read SHALL be reissued when LOCKED returns (FSM re-enters the same RD state).
REQ-029 col_ready ignored outside HOLD; col_valid SHALL never be asserted outside HOLD.
REQ-030 rom_addr SHALL be 0 whenever rom_en=0.

Reset
REQ-031 reset SHALL take priority over LOCKED and all other inputs, in any state including mid-frame.
REQ-032 Reset values: state IDLE, cnt 0, rom_addr 0, rom_en 0, col_top/mid/bot 0, col_addr 0, col_valid 0, busy 0, done 0.
REQ-033 First start is accepted on the cycle after reset deasserts.

Structure
REQ-034 Shared package edge_pkg SHALL hold ROW, ROWS, PIX_W, ADDR_W (15), LAST and the state encoding.
REQ-035 Single flat module; no sub-module is natural (address adder and FSM are too small to split).

Verification
REQ-036 Reset, LOCKED=1, start pulse, col_ready=1, ROM model data=addr[7:0] -> first col_valid on cycle 5 after start with top=0x00, mid=0x7D, bot=0xFA, col_addr=0.
REQ-037 Full frame with col_ready=1 -> exactly 31000 handshakes, last col_addr=30999 with rom_addr max 31249, done pulses once, 5*31000+2 cycles start-to-done.
REQ-038 col_ready low for 10 cycles in HOLD -> col_valid and column data stable 10 cycles, cnt unchanged, no rom_en.
REQ-039 LOCKED dropped during RD1 for 4 cycles -> rom_en=0 throughout, FSM resumes RD1 with rom_addr=cnt+125, column data correct.
REQ-040 reset asserted mid-frame in RD2 (cnt=500) -> next cycle IDLE, all outputs 0; new start restarts at col_addr=0.
REQ-041 start pulsed while busy -> ignored; frame count and done pulse count unchanged.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared geometry defaults and FSM encoding for the edge-detection frame sequencer.
package edge_pkg;
  localparam int ROW    = 125;
  localparam int ROWS   = 250;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 15;
  localparam int LAST   = ROW * (ROWS - 2) - 1;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CAP, HOLD, DONE} state_e;
endpackage

// File: rtl/edge_frame_sequencer.sv
// Walks a pixel ROM column by column, assembling 3-pixel vertical columns
// (rows r..r+2) and presenting each to a downstream Sobel core with a valid/ready handshake.
module edge_frame_sequencer #(
  parameter int ROW   = edge_pkg::ROW,
  parameter int ROWS  = edge_pkg::ROWS,
  parameter int PIX_W = edge_pkg::PIX_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        LOCKED,
  input  logic                        start,
  output logic [edge_pkg::ADDR_W-1:0] rom_addr,
  output logic                        rom_en,
  input  logic [PIX_W-1:0]            rom_data,
  output logic [PIX_W-1:0]            col_top,
  output logic [PIX_W-1:0]            col_mid,
  output logic [PIX_W-1:0]            col_bot,
  output logic [edge_pkg::ADDR_W-1:0] col_addr,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic                        busy,
  output logic                        done
);
  import edge_pkg::*;

  localparam int AW = edge_pkg::ADDR_W;
  localparam logic [AW-1:0] ROW_A  = AW'(ROW);
  localparam logic [AW-1:0] ROW2_A = AW'(2 * ROW);
  localparam logic [AW-1:0] LAST_A = AW'(ROW * (ROWS - 2) - 1);

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    addr_q;
  logic             rd_en_q;
  logic [PIX_W-1:0] top_q;
  logic [PIX_W-1:0] mid_q;
  logic [PIX_W-1:0] bot_q;
  logic [AW-1:0]    col_addr_q;
  logic             valid_q;
  logic             done_q;

  // Losing lock must suppress the read in the very cycle it drops, so the
  // registered request is gated combinationally; the state holds and reissues it.
  assign rom_en    = rd_en_q & LOCKED;
  assign rom_addr  = rom_en ? addr_q : '0;
  assign col_top   = top_q;
  assign col_mid   = mid_q;
  assign col_bot   = bot_q;
  assign col_addr  = col_addr_q;
  assign col_valid = valid_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      col_addr_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (LOCKED) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RD0;
            rd_en_q <= 1'b1;
            addr_q  <= cnt_q;
          end
        end
        RD0: begin
          state_q <= RD1;
          addr_q  <= cnt_q + ROW_A;
        end
        RD1: begin
          state_q <= RD2;
          addr_q  <= cnt_q + ROW2_A;
          top_q   <= rom_data;
        end
        RD2: begin
          state_q <= CAP;
          rd_en_q <= 1'b0;
          addr_q  <= '0;
          mid_q   <= rom_data;
        end
        CAP: begin
          state_q    <= HOLD;
          bot_q      <= rom_data;
          valid_q    <= 1'b1;
          col_addr_q <= cnt_q;
        end
        HOLD: begin
          if (col_ready) begin
            valid_q <= 1'b0;
            if (cnt_q == LAST_A) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              addr_q  <= cnt_q + 1'b1;
              rd_en_q <= 1'b1;
              state_q <= RD0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Directed + randomized bench for edge_frame_sequencer against a column-level reference model.
module tb_edge_frame_sequencer;
  localparam int ROW      = 125;
  localparam int ROWS     = 7;
  localparam int AW       = 15;
  localparam int N        = ROW * (ROWS - 2);
  localparam int LAST     = N - 1;
  localparam int MAX_ADDR = ROW * ROWS - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          LOCKED = 1'b1;
  logic          start = 1'b0;
  logic          col_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [7:0]    rom_data = 8'h00;
  logic [7:0]    col_top, col_mid, col_bot;
  logic [AW-1:0] col_addr;
  logic          col_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int exp_n = 0;
  int hs_count = 0;
  int done_cnt = 0;
  int max_addr = 0;
  int last_addr = 0;
  bit mon_on = 1'b0;
  logic p_reset = 1'b1;
  logic p_locked = 1'b1;
  logic p_ready = 1'b0;
  logic p_valid = 1'b0;
  logic [63:0] p_vec = '0;

  edge_frame_sequencer #(.ROW(ROW), .ROWS(ROWS), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .LOCKED(LOCKED), .start(start),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .col_addr(col_addr), .col_valid(col_valid), .col_ready(col_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Block-RAM style ROM: output register only updates on an enabled read.
  always @(posedge clk) if (rom_en) rom_data <= rom_addr[7:0];

  function automatic logic [63:0] outs();
    return {22'd0, col_valid, done, busy, col_top, col_mid, col_bot, col_addr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Column-level model: handshake n must carry pixels n, n+ROW, n+2*ROW.
  task automatic monitor();
    logic [7:0] et, em, eb;
    if (!mon_on) return;
    if (!p_reset) begin
      if (!p_locked) check("lock_hold", outs(), p_vec);
      else if (p_valid && !p_ready) check("hold_stable", outs(), p_vec);
    end
    check("rom_rules", {60'd0, rom_en & ~LOCKED, ~rom_en & (rom_addr != 0),
                        rom_addr > MAX_ADDR, col_valid & ~busy}, 64'd0);
    if (rom_en && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (reset) exp_n = 0;
    else if (LOCKED) begin
      if (col_valid && col_ready) begin
        et = 8'(exp_n);
        em = 8'(exp_n + ROW);
        eb = 8'(exp_n + 2 * ROW);
        check("col_over", exp_n < N, 1);
        check("col_addr", col_addr, exp_n);
        check("col_data", {col_top, col_mid, col_bot}, {et, em, eb});
        last_addr = int'(col_addr);
        exp_n++;
        hs_count++;
      end
      if (done) begin
        check("frame_len", exp_n, N);
        exp_n = 0;
        done_cnt++;
      end
    end
    p_reset  = reset;
    p_locked = LOCKED;
    p_ready  = col_ready;
    p_valid  = col_valid;
    p_vec    = outs();
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  initial begin
    int t;
    logic [63:0] snap;
    bit found;

    repeat (2) tick();
    mon_on = 1'b1;
    check("reset_outs", outs(), 64'd0);
    check("reset_rom", {rom_en, rom_addr}, 64'd0);

    // Frame 1: ready always high; a stray start while busy and one in DONE.
    reset = 0; start = 1; col_ready = 1;
    tick(); start = 0; t = 1;
    while (!col_valid && t < 20) begin tick(); t++; end
    check("first_valid_cyc", t, 5);
    check("first_col", {col_top, col_mid, col_bot, col_addr}, {8'h00, 8'h7D, 8'hFA, 15'd0});
    while (!done && t < 5 * N + 50) begin
      if (t == 100) start = 1;
      tick(); start = 0; t++;
    end
    check("start_to_done", t + 1, 5 * N + 2);
    start = 1; tick(); start = 0;
    check("done_cnt", done_cnt, 1);
    check("hs_count", hs_count, N);
    check("last_col", last_addr, LAST);
    check("max_addr", max_addr, MAX_ADDR);
    check("idle_after", {busy, done}, 0);
    repeat (3) tick();
    check("stay_idle", {busy, done, col_valid}, 0);

    // Frame 2: stall in HOLD, lock loss in RD1, then random traffic.
    hs_count = 0; done_cnt = 0;
    start = 1; col_ready = 0;
    tick(); start = 0; t = 1;
    while (!col_valid && t < 20) begin tick(); t++; end
    check("valid_stall", t, 5);
    snap = outs();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_no_rd", {rom_en, col_valid}, 2'b01);
    end
    check("stall_snap", outs(), snap);
    col_ready = 1;
    tick();
    check("rd0_addr", {rom_en, rom_addr}, {1'b1, 15'd1});
    tick();
    check("rd1_addr", {rom_en, rom_addr}, {1'b1, 15'(1 + ROW)});
    LOCKED = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lock_no_rd", rom_en, 0);
    end
    LOCKED = 1; #1;
    check("rd1_resume", {rom_en, rom_addr}, {1'b1, 15'(1 + ROW)});
    t = 0;
    while (!done && t < 30000) begin
      col_ready = ($urandom_range(0, 3) != 0);
      LOCKED    = ($urandom_range(0, 7) != 0);
      start     = ($urandom_range(0, 15) == 0);
      tick(); t++;
    end
    check("rand_done_seen", done, 1);
    start = 0; LOCKED = 1; col_ready = 0;
    tick(); tick();
    check("rand_frames", done_cnt, 1);
    check("rand_cols", hs_count, N);
    check("rand_idle", {busy, done}, 0);

    // Frame 3: reset (with lock low) while reading column 500 in RD2.
    hs_count = 0; start = 1; col_ready = 1;
    tick(); start = 0; found = 0; t = 0;
    while (!found && t < 5000) begin
      if (rom_en && rom_addr == 15'(500 + 2 * ROW)) found = 1;
      else begin tick(); t++; end
    end
    check("reach_rd2_500", found, 1);
    check("cols_before", hs_count, 500);
    reset = 1; LOCKED = 0;
    tick();
    check("midreset_outs", outs(), 64'd0);
    check("midreset_rom", {rom_en, rom_addr}, 64'd0);
    reset = 0; LOCKED = 1; start = 1;
    tick(); start = 0; t = 1;
    while (!col_valid && t < 20) begin tick(); t++; end
    check("restart_valid", t, 5);
    check("restart_col", {col_top, col_mid, col_bot, col_addr}, {8'h00, 8'h7D, 8'hFA, 15'd0});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
